// File: rtl/sign_packer.sv
// sign_packer: packs variable-length MSB-aligned sign vectors into a continuous
// MSB-first stream of 32-bit words; flush zero-pads and marks the final word.
module sign_packer #(
  parameter int unsigned IN_DEPTH = 2,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_en,
  input  logic [63:0]      in_data,
  input  logic [6:0]       in_size,
  input  logic             in_wr,
  output logic             in_full,
  input  logic             flush,
  input  logic             out_full,
  output logic [31:0]      out_word,
  output logic             out_wr,
  output logic             out_last,
  output logic             flush_done,
  output logic [CNT_W-1:0] word_count,
  output logic             err_ovf
);
  localparam int unsigned AW = (IN_DEPTH > 1) ? $clog2(IN_DEPTH) : 1;
  localparam int unsigned FW = AW + 1;

  typedef enum logic [1:0] {RUN, DRAIN, TAIL, DONE} state_t;
  state_t state, state_next;

  logic [63:0]   buf_data [IN_DEPTH];
  logic [6:0]    buf_size [IN_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [FW-1:0] fill, fill_next;
  logic [95:0]   acc, acc_shift, acc_next;
  logic [6:0]    acc_cnt, c, cnt_next, size_cl, head_size;
  logic [63:0]   head_data, head_mask;
  logic          push, pop, emit, merge, last_emit, tail_emit, buf_empty;

  always_comb begin
    size_cl   = (in_size > 7'd64) ? 7'd64 : in_size;
    buf_empty = (fill == '0);
    head_data = buf_data[rd_ptr];
    head_size = buf_size[rd_ptr];
    // upstream never clears the unused low bits, so strip them before merging
    head_mask = 64'hFFFF_FFFF_FFFF_FFFF << (7'd64 - head_size);
    push      = clk_en && in_wr && !in_full;
    emit      = clk_en && (acc_cnt >= 7'd32) && !out_full;
    acc_shift = emit ? {acc[63:0], 32'd0} : acc;
    c         = emit ? (acc_cnt - 7'd32) : acc_cnt;
    merge     = clk_en && !buf_empty && (state == RUN || state == DRAIN) &&
                (({1'b0, c} + {1'b0, head_size}) <= 8'd96);
    pop       = merge;
    acc_next  = acc_shift;
    cnt_next  = c;
    if (merge) begin
      acc_next = acc_shift | ({head_data & head_mask, 32'd0} >> c);
      cnt_next = c + head_size;
    end
    fill_next = fill + FW'(push) - FW'(pop);
    // a full word leaving DRAIN with nothing behind it closes the stream itself
    last_emit = emit && (state == DRAIN) && (c == 7'd0) && buf_empty && !push;
    tail_emit = clk_en && (state == TAIL) && !out_full;

    state_next = state;
    case (state)
      RUN:     if (flush) state_next = DRAIN;
      DRAIN:   if (buf_empty && acc_cnt < 7'd32)
                 state_next = (acc_cnt != 7'd0) ? TAIL : DONE;
      TAIL:    if (!out_full) state_next = DONE;
      DONE:    state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      buf_data[wr_ptr] <= in_data;
      buf_size[wr_ptr] <= size_cl;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= RUN;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fill       <= '0;
      in_full    <= 1'b0;
      acc        <= '0;
      acc_cnt    <= '0;
      out_word   <= '0;
      out_wr     <= 1'b0;
      out_last   <= 1'b0;
      flush_done <= 1'b0;
      word_count <= '0;
      err_ovf    <= 1'b0;
    end else begin
      out_wr     <= 1'b0;
      out_last   <= 1'b0;
      flush_done <= 1'b0;
      if (clk_en) begin
        state   <= state_next;
        fill    <= fill_next;
        in_full <= (fill_next == FW'(IN_DEPTH));
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        if (in_wr && (in_full || in_size > 7'd64)) err_ovf <= 1'b1;
        if (tail_emit) begin
          out_word <= acc[95:64];
          out_wr   <= 1'b1;
          out_last <= 1'b1;
          acc      <= '0;
          acc_cnt  <= '0;
        end else begin
          acc     <= acc_next;
          acc_cnt <= cnt_next;
          if (emit) begin
            out_word <= acc[95:64];
            out_wr   <= 1'b1;
            out_last <= last_emit;
          end
        end
        if (emit || tail_emit) word_count <= word_count + CNT_W'(1);
        if (state == DONE) begin
          flush_done <= 1'b1;
          word_count <= '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_sign_packer.sv
// Self-checking bench for sign_packer: directed scenarios plus randomized
// streams, checked against a bit-queue reference of the packed stream.
module tb_sign_packer;
  logic        clk = 0, rst = 0, clk_en = 1, in_wr = 0, flush = 0, out_full = 0;
  logic [63:0] in_data = '0;
  logic [6:0]  in_size = '0;
  logic        in_full, out_wr, out_last, flush_done, err_ovf;
  logic [31:0] out_word;
  logic [15:0] word_count;

  int checks = 0, passed = 0, failed = 0;
  bit          bits[$];
  logic [31:0] exp_w[$];
  bit          exp_l[$];

  sign_packer #(.IN_DEPTH(2), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .in_data(in_data), .in_size(in_size),
    .in_wr(in_wr), .in_full(in_full), .flush(flush), .out_full(out_full),
    .out_word(out_word), .out_wr(out_wr), .out_last(out_last),
    .flush_done(flush_done), .word_count(word_count), .err_ovf(err_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    assert (got === want) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  // Reference: accepted bits queue up in order; every 32 form the next word.
  task automatic model_push(input logic [63:0] d, input logic [6:0] s);
    int unsigned sz;
    logic [31:0] w;
    sz = (s > 7'd64) ? 64 : int'(s);
    for (int i = 0; i < int'(sz); i++) bits.push_back(d[63-i]);
    while (bits.size() >= 32) begin
      w = '0;
      for (int i = 0; i < 32; i++) w[31-i] = bits.pop_front();
      exp_w.push_back(w);
      exp_l.push_back(1'b0);
    end
  endtask

  task automatic model_flush();
    logic [31:0] w;
    if (bits.size() > 0) begin
      w = '0;
      for (int i = 0; i < bits.size(); i++) w[31-i] = bits[i];
      bits.delete();
      exp_w.push_back(w);
      exp_l.push_back(1'b1);
    end else if (exp_l.size() > 0) begin
      exp_l[exp_l.size()-1] = 1'b1;
    end
  endtask

  task automatic tick();
    logic ofull, cen;
    ofull = out_full;
    cen   = clk_en;
    @(posedge clk);
    #1;
    if (out_wr === 1'b1) begin
      chk("out_wr_gated", ofull || !cen, 0);
      chk("word_pending", exp_w.size() > 0, 1);
      if (exp_w.size() > 0) begin
        chk("out_word", out_word, exp_w.pop_front());
        chk("out_last", out_last, exp_l.pop_front());
      end
    end
  endtask

  task automatic do_write(input logic [63:0] d, input logic [6:0] s);
    bit accept;
    accept  = clk_en && !in_full;
    in_data = d;
    in_size = s;
    in_wr   = 1;
    tick();
    in_wr   = 0;
    in_data = {$urandom, $urandom};
    if (accept) model_push(d, s);
  endtask

  task automatic wait_empty(input string tag, input int budget);
    int n = 0;
    while (exp_w.size() > 0 && n < budget) begin
      tick();
      n++;
    end
    chk(tag, exp_w.size(), 0);
  endtask

  task automatic do_flush(input bit exact2);
    int n = 0;
    clk_en   = 1;
    out_full = 0;
    flush    = 1;
    tick();
    flush = 0;
    model_flush();
    if (exact2) begin
      tick();
      chk("flush_done_early", flush_done, 0);
      tick();
      chk("flush_done_t2", flush_done, 1);
    end else begin
      while (flush_done !== 1'b1 && n < 100) begin
        tick();
        n++;
      end
      chk("flush_done", flush_done, 1);
    end
    chk("word_count_cleared", word_count, 0);
    chk("flush_all_words", exp_w.size(), 0);
    tick();
    chk("flush_done_pulse", flush_done, 0);
  endtask

  task automatic do_reset();
    rst = 0;
    #1;
    chk("rst_in_full", in_full, 0);
    chk("rst_out_wr", out_wr, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_flush_done", flush_done, 0);
    chk("rst_err_ovf", err_ovf, 0);
    chk("rst_word_count", word_count, 0);
    chk("rst_out_word", out_word, 0);
    tick();
    tick();
    rst = 1;
    bits.delete();
    exp_w.delete();
    exp_l.delete();
  endtask

  initial begin
    logic [63:0] r;
    tick();
    do_reset();

    // single 64-bit vector: words at k+2 and k+3, then an empty-stream flush
    do_write(64'hDEAD_BEEF_CAFE_BABE, 7'd64);
    chk("lat_k0", out_wr, 0);
    tick();
    chk("lat_k1", out_wr, 0);
    tick();
    chk("lat_k2", out_wr, 1);
    chk("wc_1", word_count, 1);
    tick();
    chk("lat_k3", out_wr, 1);
    chk("wc_2", word_count, 2);
    tick();
    chk("idle_no_wr", out_wr, 0);
    do_flush(1);

    // seven 5-bit vectors with garbage below, then a padded tail
    for (int i = 0; i < 7; i++) begin
      r = {$urandom, $urandom};
      r = {5'b10110, r[58:1], 1'b1};
      do_write(r, 7'd5);
    end
    do_flush(0);

    // size 0 contributes nothing; only the top 32 bits of the next entry count
    do_write('1, 7'd0);
    do_write(64'h1234_5678_FFFF_FFFF, 7'd32);
    wait_empty("t3_drain", 20);
    repeat (5) tick();

    // exact word multiple: the final full word carries out_last
    do_write({$urandom, $urandom}, 7'd64);
    do_flush(0);

    // downstream stall with the input buffer filling up
    out_full = 1;
    for (int i = 0; i < 3; i++) do_write({$urandom, $urandom}, 7'd64);
    chk("stall_in_full", in_full, 1);
    repeat (7) tick();
    out_full = 0;
    wait_empty("stall_drain", 40);
    chk("stall_no_err", err_ovf, 0);

    // oversized entry is clamped to 64 bits and flagged
    do_write({$urandom, $urandom}, 7'd100);
    chk("oversize_err", err_ovf, 1);
    wait_empty("oversize_drain", 20);

    // reset with 20 bits buffered: nothing survives into the flushed stream
    do_write({$urandom, $urandom}, 7'd20);
    tick();
    tick();
    do_reset();
    do_flush(1);

    // write while full is dropped and flagged
    out_full = 1;
    for (int i = 0; i < 3; i++) do_write({$urandom, $urandom}, 7'd64);
    chk("ovf_in_full", in_full, 1);
    do_write({$urandom, $urandom}, 7'd64);
    chk("ovf_err", err_ovf, 1);
    out_full = 0;
    wait_empty("ovf_drain", 40);
    do_reset();

    // randomized streams with clock-enable gaps and downstream backpressure
    for (int s = 0; s < 3; s++) begin
      for (int i = 0; i < 150; i++) begin
        clk_en   = ($urandom_range(0, 9) != 0);
        out_full = ($urandom_range(0, 3) == 0);
        if ($urandom_range(0, 2) != 0 && !in_full)
          do_write({$urandom, $urandom}, 7'($urandom_range(0, 64)));
        else
          tick();
      end
      clk_en   = 1;
      out_full = 0;
      wait_empty("rand_drain", 200);
      do_flush(0);
    end
    chk("rand_no_err", err_ovf, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
